// File: rtl/shift_register_checker_if.sv
// Bundle of stimulus taps and result outputs for shift_register_checker.
// The bench drives the master side; the checker takes the slave side.
interface shift_register_checker_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 5,
  parameter int CNT_W    = 8
);
  localparam int LW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      ENB;
  logic                      CLEAR;
  logic [CHANNELS*WIDTH-1:0] Q_REF;
  logic [CHANNELS*WIDTH-1:0] Q_DUT;
  logic [CHANNELS-1:0]       S_REF;
  logic [CHANNELS-1:0]       S_DUT;
  logic [CHANNELS-1:0]       LANE_MASK;
  logic [CHANNELS-1:0]       MISMATCH;
  logic [CHANNELS-1:0]       STICKY;
  logic [CNT_W-1:0]          ERR_COUNT;
  logic [CNT_W-1:0]          CYCLE_COUNT;
  logic                      FIRST_VALID;
  logic [LW-1:0]             FIRST_LANE;
  logic [CNT_W-1:0]          FIRST_CYCLE;
  logic                      FAIL;

  modport master (
    output ENB, CLEAR, Q_REF, Q_DUT,
    output S_REF, S_DUT, LANE_MASK,
    input  MISMATCH, STICKY, ERR_COUNT,
    input  CYCLE_COUNT, FIRST_VALID,
    input  FIRST_LANE, FIRST_CYCLE, FAIL
  );

  modport slave (
    input  ENB, CLEAR, Q_REF, Q_DUT,
    input  S_REF, S_DUT, LANE_MASK,
    output MISMATCH, STICKY, ERR_COUNT,
    output CYCLE_COUNT, FIRST_VALID,
    output FIRST_LANE, FIRST_CYCLE, FAIL
  );
endinterface

// File: rtl/shift_register_checker.sv
// Lane-parallel comparator of reference vs DUT shift registers with
// settle gating, sticky flags, saturating counters and first-error capture.
module shift_register_checker #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 5,
  parameter int CNT_W    = 8,
  parameter int SETTLE   = 2
) (
  input logic CLK,
  input logic RESET,
  shift_register_checker_if.slave bus
);
  localparam int LW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = $clog2(CHANNELS + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int EW = CNT_W + PW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK
  } state_t;

  state_t state, state_nx;
  logic [SW-1:0] settle_cnt, settle_nx;

  logic [CHANNELS-1:0] lane_mm;
  logic [PW-1:0]       pop;
  logic [LW-1:0]       low_lane;
  logic [EW-1:0]       err_sum;
  logic                in_check;

  logic [CHANNELS-1:0] mm_q, sticky_q;
  logic [CNT_W-1:0]    err_q, cyc_q, fcyc_q;
  logic                fvalid_q;
  logic [LW-1:0]       flane_q;

  assign in_check = (state == ST_CHECK);

  // Scan high-to-low so the last hit left in low_lane is the lowest lane.
  always_comb begin
    lane_mm  = '0;
    pop      = '0;
    low_lane = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_check && bus.LANE_MASK[i] &&
          ((bus.Q_REF[i*WIDTH +: WIDTH] !=
            bus.Q_DUT[i*WIDTH +: WIDTH]) ||
           (bus.S_REF[i] != bus.S_DUT[i]))) begin
        lane_mm[i] = 1'b1;
        pop        = pop + PW'(1);
        low_lane   = LW'(i);
      end
    end
  end

  assign err_sum = EW'(err_q) + EW'(pop);

  // The IDLE->SETTLE edge counts as the first settle cycle.
  always_comb begin
    state_nx  = state;
    settle_nx = settle_cnt;
    unique case (state)
      ST_IDLE: begin
        if (bus.ENB) begin
          state_nx  = ST_SETTLE;
          settle_nx = SW'(1);
        end
      end
      ST_SETTLE: begin
        if (!bus.ENB)
          state_nx = ST_IDLE;
        else if (int'(settle_cnt) + 1 >= SETTLE)
          state_nx = ST_CHECK;
        else
          settle_nx = settle_cnt + SW'(1);
      end
      ST_CHECK: begin
        if (!bus.ENB)
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nx;
      settle_cnt <= settle_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || bus.CLEAR) begin
      mm_q     <= '0;
      sticky_q <= '0;
      err_q    <= '0;
      cyc_q    <= '0;
      fvalid_q <= 1'b0;
      flane_q  <= '0;
      fcyc_q   <= '0;
    end else begin
      mm_q     <= lane_mm;
      sticky_q <= sticky_q | lane_mm;
      if (err_sum > EW'(CNT_MAX))
        err_q <= CNT_MAX;
      else
        err_q <= err_sum[CNT_W-1:0];
      if (in_check && cyc_q != CNT_MAX)
        cyc_q <= cyc_q + CNT_W'(1);
      if (|lane_mm && !fvalid_q) begin
        fvalid_q <= 1'b1;
        flane_q  <= low_lane;
        fcyc_q   <= cyc_q;
      end
    end
  end

  assign bus.MISMATCH    = mm_q;
  assign bus.STICKY      = sticky_q;
  assign bus.ERR_COUNT   = err_q;
  assign bus.CYCLE_COUNT = cyc_q;
  assign bus.FIRST_VALID = fvalid_q;
  assign bus.FIRST_LANE  = flane_q;
  assign bus.FIRST_CYCLE = fcyc_q;
  assign bus.FAIL        = |sticky_q;
endmodule

// File: tb/tb_shift_register_checker.sv
// Directed, table-driven bench for shift_register_checker: a CNT_W=8
// instance for the main flow and a CNT_W=4 instance for saturation.
module tb_shift_register_checker;
  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  shift_register_checker_if #(.WIDTH(4), .CHANNELS(5), .CNT_W(8)) m ();
  shift_register_checker_if #(.WIDTH(4), .CHANNELS(5), .CNT_W(4)) s ();

  shift_register_checker #(
    .WIDTH(4), .CHANNELS(5), .CNT_W(8), .SETTLE(2)
  ) u_main (
    .CLK(CLK), .RESET(RESET), .bus(m.slave)
  );

  shift_register_checker #(
    .WIDTH(4), .CHANNELS(5), .CNT_W(4), .SETTLE(2)
  ) u_sat (
    .CLK(CLK), .RESET(RESET), .bus(s.slave)
  );

  typedef struct {
    logic        clr;
    logic [19:0] qr;
    logic [19:0] qd;
    logic [4:0]  sr;
    logic [4:0]  sd;
    logic [4:0]  mk;
    logic [4:0]  mm;
    logic [4:0]  st;
    logic [7:0]  er;
    logic [7:0]  cy;
    logic        fv;
    logic [2:0]  fl;
    logic [7:0]  fc;
  } vec_t;

  localparam logic [19:0] QB = 20'h4B2E7;
  localparam logic [4:0]  SB = 5'b10110;

  int n_chk  = 0;
  int n_pass = 0;
  vec_t vt[14];

  function automatic vec_t v(
    input logic clr, input logic [19:0] qd,
    input logic [4:0] sd, input logic [4:0] mk,
    input logic [4:0] mm, input logic [4:0] st,
    input logic [7:0] er, input logic [7:0] cy,
    input logic fv, input logic [2:0] fl,
    input logic [7:0] fc);
    vec_t r;
    r.clr = clr; r.qr = QB; r.qd = qd;
    r.sr = SB; r.sd = sd; r.mk = mk;
    r.mm = mm; r.st = st; r.er = er; r.cy = cy;
    r.fv = fv; r.fl = fl; r.fc = fc;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic chk_m(input string t,
                       input logic [4:0] mm, input logic [4:0] st,
                       input logic [7:0] er, input logic [7:0] cy,
                       input logic fv, input logic [2:0] fl,
                       input logic [7:0] fc);
    chk({t, ".mm"},   32'(m.MISMATCH),    32'(mm));
    chk({t, ".st"},   32'(m.STICKY),      32'(st));
    chk({t, ".err"},  32'(m.ERR_COUNT),   32'(er));
    chk({t, ".cyc"},  32'(m.CYCLE_COUNT), 32'(cy));
    chk({t, ".fv"},   32'(m.FIRST_VALID), 32'(fv));
    chk({t, ".fl"},   32'(m.FIRST_LANE),  32'(fl));
    chk({t, ".fc"},   32'(m.FIRST_CYCLE), 32'(fc));
    chk({t, ".fail"}, 32'(m.FAIL),        32'(|st));
  endtask

  task automatic chk_s(input string t,
                       input logic [4:0] mm, input logic [3:0] er,
                       input logic [3:0] cy, input logic fv);
    chk({t, ".mm"},   32'(s.MISMATCH),    32'(mm));
    chk({t, ".st"},   32'(s.STICKY),      32'(fv ? 5'h1f : 5'h0));
    chk({t, ".err"},  32'(s.ERR_COUNT),   32'(er));
    chk({t, ".cyc"},  32'(s.CYCLE_COUNT), 32'(cy));
    chk({t, ".fv"},   32'(s.FIRST_VALID), 32'(fv));
    chk({t, ".fl"},   32'(s.FIRST_LANE),  32'(0));
    chk({t, ".fc"},   32'(s.FIRST_CYCLE), 32'(0));
    chk({t, ".fail"}, 32'(s.FAIL),        32'(fv));
  endtask

  task automatic set_m(input logic clr,
                       input logic [19:0] qr, input logic [19:0] qd,
                       input logic [4:0] sr, input logic [4:0] sd,
                       input logic [4:0] mk);
    m.CLEAR = clr; m.Q_REF = qr; m.Q_DUT = qd;
    m.S_REF = sr; m.S_DUT = sd; m.LANE_MASK = mk;
  endtask

  task automatic set_s(input logic clr, input logic bad);
    s.CLEAR = clr; s.Q_REF = QB; s.S_REF = SB;
    s.Q_DUT = bad ? ~QB : QB;
    s.S_DUT = bad ? ~SB : SB;
    s.LANE_MASK = 5'h1f;
  endtask

  initial begin
    logic [19:0] rq;
    logic [4:0]  rs;

    vt[0]  = v(0, QB,         SB,       5'h1f, 5'h00, 5'h00, 0, 1, 0, 0, 0);
    vt[1]  = v(0, QB,         SB,       5'h1f, 5'h00, 5'h00, 0, 2, 0, 0, 0);
    vt[2]  = v(0, QB,         SB,       5'h1f, 5'h00, 5'h00, 0, 3, 0, 0, 0);
    vt[3]  = v(0, 20'h4B3E7,  SB,       5'h1b, 5'h00, 5'h00, 0, 4, 0, 0, 0);
    vt[4]  = v(0, QB,         SB,       5'h1f, 5'h00, 5'h00, 0, 5, 0, 0, 0);
    vt[5]  = v(0, QB,         SB,       5'h1f, 5'h00, 5'h00, 0, 6, 0, 0, 0);
    vt[6]  = v(0, QB,         SB,       5'h1f, 5'h00, 5'h00, 0, 7, 0, 0, 0);
    vt[7]  = v(0, 20'h4A2E7,  SB,       5'h1f, 5'h08, 5'h08, 1, 8, 1, 3, 7);
    vt[8]  = v(0, QB,         SB,       5'h1f, 5'h00, 5'h08, 1, 9, 1, 3, 7);
    vt[9]  = v(0, QB,         5'b00100, 5'h1f, 5'h12, 5'h1a, 3, 10, 1, 3, 7);
    vt[10] = v(1, QB,         SB,       5'h1f, 5'h00, 5'h00, 0, 0, 0, 0, 0);
    vt[11] = v(0, QB,         5'b00100, 5'h1f, 5'h12, 5'h12, 2, 1, 1, 1, 0);
    vt[12] = v(0, 20'h4B2E6,  SB,       5'h1f, 5'h01, 5'h13, 3, 2, 1, 1, 0);
    vt[13] = v(0, QB,         SB,       5'h1f, 5'h00, 5'h13, 3, 3, 1, 1, 0);

    RESET = 1'b1;
    m.ENB = 1'b0;
    s.ENB = 1'b0;
    set_m(0, QB, QB, SB, SB, 5'h1f);
    set_s(0, 0);
    tick();
    tick();
    chk_m("reset", 0, 0, 0, 0, 0, 0, 0);
    chk_s("sat_reset", 0, 0, 0, 0);
    RESET = 1'b0;

    // Every lane wrong during settle: must not be counted.
    m.ENB = 1'b1;
    set_m(0, QB, ~QB, SB, ~SB, 5'h1f);
    tick();
    chk_m("settle0", 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_m("settle1", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 50; i++) begin
      rq = 20'($urandom);
      rs = 5'($urandom);
      set_m(0, rq, rq, rs, rs, 5'h1f);
      tick();
    end
    chk_m("matched50", 0, 0, 0, 50, 0, 0, 0);

    set_m(1, QB, QB, SB, SB, 5'h1f);
    tick();
    chk_m("clear_pre", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      set_m(vt[i].clr, vt[i].qr, vt[i].qd,
            vt[i].sr, vt[i].sd, vt[i].mk);
      tick();
      chk_m($sformatf("vec%0d", i), vt[i].mm, vt[i].st,
            vt[i].er, vt[i].cy, vt[i].fv,
            vt[i].fl, vt[i].fc);
    end

    // Reset mid-CHECK with ERR_COUNT=3 overrides ENB and CLEAR.
    RESET = 1'b1;
    set_m(1, QB, ~QB, SB, ~SB, 5'h1f);
    tick();
    chk_m("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    RESET = 1'b0;
    m.CLEAR = 1'b0;
    tick();
    chk_m("reen0", 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_m("reen1", 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_m("reen2", 5'h1f, 5'h1f, 5, 1, 1, 0, 0);

    // Leaving CHECK holds results even with faults in IDLE.
    m.ENB = 1'b0;
    set_m(0, QB, QB, SB, SB, 5'h1f);
    tick();
    chk("off0.mm",  32'(m.MISMATCH),  32'(0));
    chk("off0.err", 32'(m.ERR_COUNT), 32'(5));
    set_m(0, QB, ~QB, SB, ~SB, 5'h1f);
    tick();
    chk("off1.mm",   32'(m.MISMATCH),    32'(0));
    chk("off1.err",  32'(m.ERR_COUNT),   32'(5));
    chk("off1.st",   32'(m.STICKY),      32'(5'h1f));
    chk("off1.fv",   32'(m.FIRST_VALID), 32'(1));
    chk("off1.fail", 32'(m.FAIL),        32'(1));

    s.ENB = 1'b1;
    set_s(0, 0);
    tick();
    chk_s("sat_settle0", 0, 0, 0, 0);
    tick();
    chk_s("sat_settle1", 0, 0, 0, 0);
    set_s(0, 1);
    tick();
    chk_s("sat1", 5'h1f, 5, 1, 1);
    tick();
    chk_s("sat2", 5'h1f, 10, 2, 1);
    tick();
    chk_s("sat3", 5'h1f, 15, 3, 1);
    tick();
    chk_s("sat4", 5'h1f, 15, 4, 1);
    tick();
    chk_s("sat5", 5'h1f, 15, 5, 1);
    set_s(1, 1);
    tick();
    chk_s("sat_clr", 0, 0, 0, 0);
    set_s(0, 1);
    tick();
    chk_s("sat_after", 5'h1f, 5, 1, 1);
    set_s(0, 0);
    for (int i = 0; i < 20; i++)
      tick();
    chk_s("sat_cyc", 0, 5, 15, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
